// File: rtl/hls_mem_harness_pkg.sv
// hls_mem_harness_pkg
// Shared definitions for the HLS memory harness: sequencer state encoding,
// default RAM geometry and the count clamp used for load/dump lengths.
package hls_mem_harness_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DUMP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Limit a requested word count to the RAM depth (2^addr_w).
  function automatic logic [31:0] clamp_count(input logic [31:0] cnt,
                                               input int unsigned addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/hls_mem_harness_dump.sv
// hls_mem_harness_dump
// Result-stream generator: walks the RAM debug read address from base for
// count words (wrapping modulo 2^ADDR_W) and presents each word on a
// valid/ready port. The address only advances on a handshake, so it is held
// (and the combinational RAM data with it) while the consumer stalls.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   active        high while the sequencer is in the dump state
//   base, count   first address and (already clamped) word count
//   dump_ready    consumer ready
//   dump_valid    word available (equals active)
//   dump_last     current word is the final one
//   fin           final word handshaken this cycle
//   debug_addr    RAM debug read address
module hls_mem_harness_dump
  import hls_mem_harness_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic              dump_last,
  output logic              fin,
  output logic [ADDR_W-1:0] debug_addr
);

  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] idx;

  assign dump_valid = active;
  // Natural truncation of the sum gives the wrap past the top of RAM.
  assign debug_addr = base + idx[ADDR_W-1:0];
  assign dump_last  = active && (idx == count - CNT_W'(1));
  assign fin        = dump_valid && dump_ready && dump_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (!active) begin
      idx <= '0;
    end else if (dump_valid && dump_ready) begin
      idx <= idx + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hls_mem_harness.sv
// hls_mem_harness
// Sequencer for the debug side of a kernel's shared RAM. It preloads RAM
// from a valid/ready stream, releases the kernel from reset, waits for the
// kernel's completion flag, then streams a RAM window out over valid/ready.
//
// Optional feature: define HLS_MEM_HARNESS_TIMEOUT_EN to add a RUN-state
// watchdog; after TIMEOUT_CYCLES RUN cycles without kern_valid the sequencer
// enters ERR and raises timeout. Without the macro RUN waits indefinitely
// and timeout is tied low.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   start                            begin a sequence (IDLE/DONE/ERR only)
//   load_count, dump_base, dump_count  sequence configuration, sampled at start
//   ld_valid/ld_ready/ld_data        preload stream
//   debug_write_addr/_data/_en       registered RAM debug write port
//   debug_addr / debug_data          RAM debug read port (data combinational)
//   kern_rst / kern_valid            kernel reset and completion
//   dump_valid/ready/data/last       result stream
//   busy, done, timeout              status
module hls_mem_harness
  import hls_mem_harness_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_count,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_count,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] debug_write_addr,
  output logic [DATA_W-1:0] debug_write_data,
  output logic              debug_write_en,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              kern_rst,
  input  logic              kern_valid,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = ADDR_W + 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state, state_nxt;

  logic [CNT_W-1:0]  load_cnt_c, dump_cnt_c;
  logic [CNT_W-1:0]  load_cnt_q, dump_cnt_q;
  logic [CNT_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] dump_base_q;
  logic              start_ok, ld_fire, ld_last;
  logic              dump_active, dump_fin, wd_expire;

  assign load_cnt_c = CNT_W'(clamp_count(32'(load_count), ADDR_W));
  assign dump_cnt_c = CNT_W'(clamp_count(32'(dump_count), ADDR_W));

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                              (state == ST_ERR));
  assign ld_fire  = ld_valid && ld_ready;
  assign ld_last  = ld_fire && (wr_idx == load_cnt_q - CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = (load_cnt_c == '0) ? ST_SETTLE : ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_last) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: state_nxt = ST_RUN;
      ST_RUN: begin
        if (kern_valid)     state_nxt = (dump_cnt_q == '0) ? ST_DONE : ST_DUMP;
        else if (wd_expire) state_nxt = ST_ERR;
      end
      ST_DUMP: begin
        if (dump_fin) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ld_ready    = 1'b0;
    kern_rst    = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    dump_active = 1'b0;
    unique case (state)
      ST_LOAD: begin
        busy     = 1'b1;
        ld_ready = (wr_idx < load_cnt_q);
      end
      ST_SETTLE: busy = 1'b1;
      ST_RUN: begin
        busy     = 1'b1;
        kern_rst = 1'b0;
      end
      ST_DUMP: begin
        busy        = 1'b1;
        kern_rst    = 1'b0;
        dump_active = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR: begin
`ifdef HLS_MEM_HARNESS_TIMEOUT_EN
        timeout = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Load path and sequence configuration; the debug write port is registered
  // so a handshake in one cycle appears on the RAM port the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx           <= '0;
      load_cnt_q       <= '0;
      dump_cnt_q       <= '0;
      dump_base_q      <= '0;
      debug_write_en   <= 1'b0;
      debug_write_addr <= '0;
      debug_write_data <= '0;
    end else begin
      debug_write_en <= ld_fire;
      if (ld_fire) begin
        debug_write_addr <= wr_idx[ADDR_W-1:0];
        debug_write_data <= ld_data;
      end
      if (start_ok) begin
        load_cnt_q  <= load_cnt_c;
        dump_cnt_q  <= dump_cnt_c;
        dump_base_q <= dump_base;
        wr_idx      <= '0;
      end else if (ld_fire) begin
        wr_idx <= wr_idx + CNT_W'(1);
      end
    end
  end

`ifdef HLS_MEM_HARNESS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts RUN cycles; expiry fires on the last permitted RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != ST_RUN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expire = (state == ST_RUN) &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  hls_mem_harness_dump #(
    .ADDR_W(ADDR_W)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .active    (dump_active),
    .base      (dump_base_q),
    .count     (dump_cnt_q),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_last (dump_last),
    .fin       (dump_fin),
    .debug_addr(debug_addr)
  );

  // RAM read data is combinational from debug_addr; gated so the port idles at 0.
  assign dump_data = dump_valid ? debug_data : '0;

endmodule

// File: tb/tb_hls_mem_harness.sv
module tb_hls_mem_harness;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_count = '0;
  logic [ADDR_W-1:0] dump_base = '0;
  logic [ADDR_W:0]   dump_count = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic [ADDR_W-1:0] debug_write_addr;
  logic [DATA_W-1:0] debug_write_data;
  logic              debug_write_en;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data;
  logic              kern_rst;
  logic              kern_valid = 1'b0;
  logic              dump_valid;
  logic              dump_ready = 1'b1;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy, done, timeout;

  // Kernel-side RAM write port driven by the bench
  logic              kern_we = 1'b0;
  logic [ADDR_W-1:0] kern_waddr = '0;
  logic [DATA_W-1:0] kern_wdata = '0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;

  logic [ADDR_W-1:0] exp_wr_addr[$];
  logic [DATA_W-1:0] exp_wr_data[$];
  logic [ADDR_W-1:0] exp_dp_addr[$];
  logic [DATA_W-1:0] exp_dp_data[$];
  logic              exp_dp_last[$];

  always #5 clk = ~clk;

  hls_mem_harness #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_count(load_count), .dump_base(dump_base), .dump_count(dump_count),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .debug_write_addr(debug_write_addr), .debug_write_data(debug_write_data),
    .debug_write_en(debug_write_en),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .kern_rst(kern_rst), .kern_valid(kern_valid),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_last(dump_last),
    .busy(busy), .done(done), .timeout(timeout)
  );

  // Shared RAM: debug write port plus kernel write port, combinational read
  always @(posedge clk) begin
    if (debug_write_en) mem[debug_write_addr] <= debug_write_data;
    if (kern_we)        mem[kern_waddr]       <= kern_wdata;
  end
  assign debug_data = mem[debug_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (debug_write_en) begin
        wr_pulses++;
        chk("wr_expected", 32'(exp_wr_addr.size() != 0), 32'd1);
        if (exp_wr_addr.size() != 0) begin
          chk("wr_addr", 32'(debug_write_addr), 32'(exp_wr_addr.pop_front()));
          chk("wr_data", debug_write_data, exp_wr_data.pop_front());
        end
      end
      if (dump_valid && dump_ready) begin
        chk("dump_expected", 32'(exp_dp_addr.size() != 0), 32'd1);
        if (exp_dp_addr.size() != 0) begin
          chk("dump_addr", 32'(debug_addr), 32'(exp_dp_addr.pop_front()));
          chk("dump_data", dump_data, exp_dp_data.pop_front());
          chk("dump_last", 32'(dump_last), 32'(exp_dp_last.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int lc, input int db, input int dc);
    load_count = (ADDR_W+1)'(lc);
    dump_base  = ADDR_W'(db);
    dump_count = (ADDR_W+1)'(dc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [DATA_W-1:0] d, input int gap);
    bit hs = 1'b0;
    ld_valid = 1'b1;
    ld_data  = d;
    exp_wr_addr.push_back(idx[ADDR_W-1:0]);
    exp_wr_data.push_back(d);
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = ld_ready;
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    chk("ld_handshake", 32'(hs), 32'd1);
    repeat (gap) begin
      chk("kern_rst_in_load", 32'(kern_rst), 32'd1);
      tick();
    end
  endtask

  task automatic push_dump(input int a, input logic [DATA_W-1:0] d, input bit last);
    exp_dp_addr.push_back(ADDR_W'(a));
    exp_dp_data.push_back(d);
    exp_dp_last.push_back(last);
  endtask

  task automatic pulse_kern_valid();
    kern_valid = 1'b1;
    tick();
    kern_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    chk({tag, "_drained"}, 32'(exp_dp_addr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base_pulses;
    int run_cycles;
    int guard;

    // Reset state
    #3;
    chk("rst_kern_rst", 32'(kern_rst), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_wr_en", 32'(debug_write_en), 32'd0);
    chk("rst_dump_last", 32'(dump_last), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Load 1,2,3; kernel writes 6 at addr 3; dump one word from addr 3
    do_start(3, 3, 1);
    chk("t1_ld_ready", 32'(ld_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_word(0, 32'd1, 0);
    send_word(1, 32'd2, 0);
    send_word(2, 32'd3, 0);
    chk("t1_settle_kern_rst", 32'(kern_rst), 32'd1);
    chk("t1_settle_wr_en", 32'(debug_write_en), 32'd1);
    tick();
    chk("t1_run_kern_rst", 32'(kern_rst), 32'd0);
    chk("t1_run_wr_en", 32'(debug_write_en), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_start_ignored", 32'(kern_rst), 32'd0);
    chk("t1_busy_start_ld_ready", 32'(ld_ready), 32'd0);
    kern_we = 1'b1; kern_waddr = 5'd3; kern_wdata = 32'd6;
    tick();
    kern_we = 1'b0;
    push_dump(3, 32'd6, 1'b1);
    pulse_kern_valid();
    chk("t1_dump_valid", 32'(dump_valid), 32'd1);
    chk("t1_dump_data", dump_data, 32'd6);
    wait_done("t1_done");
    chk("t1_done_kern_rst", 32'(kern_rst), 32'd1);

    // Gaps of 2 cycles between preload words; start from DONE
    do_start(3, 0, 3);
    chk("t2_done_cleared", 32'(done), 32'd0);
    base_pulses = wr_pulses;
    send_word(0, 32'd11, 2);
    send_word(1, 32'd12, 2);
    send_word(2, 32'd13, 0);
    chk("t2_settle_kern_rst", 32'(kern_rst), 32'd1);
    tick();
    chk("t2_run_kern_rst", 32'(kern_rst), 32'd0);
    chk("t2_write_pulses", 32'(wr_pulses - base_pulses), 32'd3);
    push_dump(0, 32'd11, 1'b0);
    push_dump(1, 32'd12, 1'b0);
    push_dump(2, 32'd13, 1'b1);
    pulse_kern_valid();
    wait_done("t2_done");

    // load_count 40 clamps to 32; dump wraps 30,31,0,1 with a 3-cycle stall
    do_start(40, 30, 4);
    base_pulses = wr_pulses;
    for (int i = 0; i < 32; i++) send_word(i, 32'(100 + i), 0);
    chk("t3_clamp_settle", 32'(kern_rst), 32'd1);
    tick();
    chk("t3_clamp_run", 32'(kern_rst), 32'd0);
    chk("t3_write_pulses", 32'(wr_pulses - base_pulses), 32'd32);
    push_dump(30, 32'd130, 1'b0);
    push_dump(31, 32'd131, 1'b0);
    push_dump(0, 32'd100, 1'b0);
    push_dump(1, 32'd101, 1'b1);
    dump_ready = 1'b1;
    pulse_kern_valid();
    chk("t3_first_addr", 32'(debug_addr), 32'd30);
    tick();
    tick();
    dump_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("t3_stall_addr", 32'(debug_addr), 32'd0);
      chk("t3_stall_data", dump_data, 32'd100);
      chk("t3_stall_valid", 32'(dump_valid), 32'd1);
      chk("t3_stall_last", 32'(dump_last), 32'd0);
      tick();
    end
    dump_ready = 1'b1;
    wait_done("t3_done");

    // load_count 0 and dump_count 0
    do_start(0, 0, 0);
    chk("t4_settle_busy", 32'(busy), 32'd1);
    chk("t4_settle_ld_ready", 32'(ld_ready), 32'd0);
    chk("t4_settle_kern_rst", 32'(kern_rst), 32'd1);
    tick();
    chk("t4_run_kern_rst", 32'(kern_rst), 32'd0);
    pulse_kern_valid();
    chk("t4_done_next", 32'(done), 32'd1);
    chk("t4_no_dump", 32'(dump_valid), 32'd0);
    pulse_kern_valid();
    chk("t4_kv_ignored_done", 32'(done), 32'd1);
    chk("t4_kv_ignored_kern_rst", 32'(kern_rst), 32'd1);

`ifdef HLS_MEM_HARNESS_TIMEOUT_EN
    // Watchdog: kern_valid never rises
    do_start(0, 0, 1);
    run_cycles = 0;
    guard = 0;
    while (timeout !== 1'b1 && guard < 50) begin
      if (kern_rst === 1'b0) run_cycles++;
      tick();
      guard++;
    end
    chk("t5_timeout", 32'(timeout), 32'd1);
    chk("t5_run_cycles", 32'(run_cycles), 32'd8);
    chk("t5_kern_rst", 32'(kern_rst), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    do_start(0, 0, 0);
    chk("t5_timeout_cleared", 32'(timeout), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    tick();
    pulse_kern_valid();
    chk("t5_done", 32'(done), 32'd1);
`else
    // No watchdog: RUN waits for kern_valid indefinitely
    do_start(0, 0, 0);
    run_cycles = 0;
    guard = 0;
    repeat (30) tick();
    chk("t5_no_timeout", 32'(timeout), 32'd0);
    chk("t5_still_run", 32'(kern_rst), 32'd0);
    chk("t5_still_busy", 32'(busy), 32'd1);
    pulse_kern_valid();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_done_timeout", 32'(timeout), 32'd0);
`endif

    // Reset mid-LOAD with a write in flight, then a clean restart
    do_start(3, 0, 3);
    send_word(0, 32'd50, 0);
    ld_valid = 1'b1;
    ld_data  = 32'd51;
    rst = 1'b1;
    #1;
    chk("t6_kern_rst", 32'(kern_rst), 32'd1);
    chk("t6_ld_ready", 32'(ld_ready), 32'd0);
    chk("t6_wr_en", 32'(debug_write_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    exp_wr_addr.delete();
    exp_wr_data.delete();
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_done", 32'(done), 32'd0);
    do_start(3, 0, 3);
    send_word(0, 32'd7, 0);
    send_word(1, 32'd8, 0);
    send_word(2, 32'd9, 0);
    tick();
    chk("t6_run_kern_rst", 32'(kern_rst), 32'd0);
    push_dump(0, 32'd7, 1'b0);
    push_dump(1, 32'd8, 1'b0);
    push_dump(2, 32'd9, 1'b1);
    pulse_kern_valid();
    wait_done("t6_done");
    chk("t6_wr_drained", 32'(exp_wr_addr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
